i2s_dac_tx: RTL and testbench

- Transmit-side serializer for the WM8731 audio path. Accepts stereo 24-bit samples through the same read/write-style handshake the codec exposes (write, write_ready, writedata_left/right).
- Shifts the samples out on AUD_DACDAT in I2S format. The codec is bus master and drives AUD_BCLK and AUD_DACLRCK.
- Buffers samples in a small FIFO so that looper and filter blocks can push bursts of samples ahead of the frame timing.

---
 rtl/audio_pkg.sv | 13 +
 rtl/stereo_sample_fifo.sv | 54 +++++
 rtl/i2s_dac_tx.sv | 141 ++++++++++++++
 tb/tb_i2s_dac_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types: transmit FSM states and the stereo sample pair.
package audio_pkg;

  localparam int unsigned DATA_WIDTH = 24;

  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} tx_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/stereo_sample_fifo.sv
// Synchronous FIFO of stereo sample pairs; a pop while empty is ignored.
module stereo_sample_fifo #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [2*DATA_WIDTH-1:0]       wdata_i,
  output logic [2*DATA_WIDTH-1:0]       rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(FIFO_DEPTH);

  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]           count_q;
  logic                    push_ok, pop_ok;

  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmit serializer for the WM8731 DAC; codec is BCLK/LRCK master.
module i2s_dac_tx #(
  parameter int unsigned DATA_WIDTH = audio_pkg::DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SLOT_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata_left,
  input  logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  write_ready,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  underflow
);

  import audio_pkg::*;

  localparam int unsigned CntW     = $clog2(SLOT_BITS + 1);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0]     LastBit  = CntW'(DATA_WIDTH);
  localparam logic [FifoCntW-1:0] FifoMax  = FifoCntW'(FIFO_DEPTH);

  logic [2:0] bclk_sync_q, lrck_sync_q;
  logic       bclk_fall, lrck_fall, lrck_rise;

  logic [2*DATA_WIDTH-1:0] fifo_rdata;
  logic                    fifo_full, fifo_empty, push;
  logic [FifoCntW-1:0]     fifo_count;

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  dacdat_q, dacdat_d;
  logic                  underflow_q, underflow_d;

  // Two flops resynchronise the codec clocks; the third gives the previous value.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[1:0], AUD_DACLRCK};
    end
  end

  assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lrck_fall = lrck_sync_q[2] & ~lrck_sync_q[1];
  assign lrck_rise = ~lrck_sync_q[2] & lrck_sync_q[1];

  assign write_ready = ~fifo_full;
  assign push        = write & write_ready;

  stereo_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .pop_i   (lrck_fall),
    .wdata_i ({writedata_left, writedata_right}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    dacdat_d    = dacdat_q;
    underflow_d = underflow_q;

    // A left-slot start wins over a coincident BCLK fall in every state.
    if (lrck_fall) begin
      state_d  = LEFT;
      cnt_d    = '0;
      dacdat_d = 1'b0;
      if (fifo_empty) begin
        shift_d     = '0;
        hold_d      = '0;
        underflow_d = 1'b1;
      end else begin
        shift_d = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
        hold_d  = fifo_rdata[DATA_WIDTH-1:0];
      end
    end else if (state_q == LEFT && lrck_rise) begin
      state_d  = RIGHT;
      shift_d  = hold_q;
      cnt_d    = '0;
      dacdat_d = 1'b0;
    end else begin
      case (state_q)
        LEFT, RIGHT: begin
          if (bclk_fall) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (cnt_q < LastBit) begin
              dacdat_d = shift_q[DATA_WIDTH-1];
              shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
              dacdat_d = 1'b0;
            end
          end
        end
        default: dacdat_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_SYNC;
      shift_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      dacdat_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      dacdat_q    <= dacdat_d;
      underflow_q <= underflow_d;
    end
  end

  assign AUD_DACDAT = dacdat_q;
  assign underflow  = underflow_q;

  a_fifo_count_bound : assert property (@(posedge clk) disable iff (reset)
    fifo_count <= FifoMax);

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: codec model, sample queue model, slot monitor.
`timescale 1ns/100ps
module tb_i2s_dac_tx;
  import audio_pkg::*;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SLOT  = 32;
  localparam real BclkHalf = 162.5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write = 1'b0;
  logic [DW-1:0] wl = '0;
  logic [DW-1:0] wr = '0;
  logic          write_ready, AUD_DACDAT, underflow;
  logic          bclk = 1'b1;
  logic          lrck = 1'b1;

  i2s_dac_tx #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .SLOT_BITS  (SLOT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .write           (write),
    .writedata_left  (wl),
    .writedata_right (wr),
    .write_ready     (write_ready),
    .AUD_BCLK        (bclk),
    .AUD_DACLRCK     (lrck),
    .AUD_DACDAT      (AUD_DACDAT),
    .underflow       (underflow)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  stereo_sample_t model_q[$];
  logic [DW-1:0]  exp_q[$];
  logic [DW-1:0]  pend_right = '0;
  bit             synced = 1'b0;
  bit             exp_uf = 1'b0;
  bit             codec_on = 1'b0;
  bit             slot_taint = 1'b0;
  int             c_cnt = 16;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Expected content of the slot that starts now.
  function automatic void slot_start(input logic new_lrck);
    stereo_sample_t p;
    if (!new_lrck) begin
      synced = 1'b1;
      if (model_q.size() > 0) begin
        p = model_q.pop_front();
        exp_q.push_back(p.left);
        pend_right = p.right;
      end else begin
        exp_q.push_back('0);
        pend_right = '0;
        exp_uf = 1'b1;
      end
    end else begin
      exp_q.push_back(synced ? pend_right : '0);
    end
  endfunction

  // Codec: LRCK changes on a BCLK falling edge every SLOT bit clocks.
  initial begin
    wait (codec_on);
    #3;
    forever begin
      #(BclkHalf) bclk = 1'b0;
      c_cnt++;
      if (c_cnt == SLOT) begin
        c_cnt = 0;
        lrck = ~lrck;
        slot_start(lrck);
      end
      #(BclkHalf) bclk = 1'b1;
    end
  end

  // Monitor: codec samples on BCLK rise; a slot holds 1 delay bit, DW data bits, padding.
  initial begin
    logic          mon_lrck;
    bit            active;
    logic [31:0]   word;
    logic [DW-1:0] e;
    mon_lrck = 1'b1;
    active = 1'b0;
    word = '0;
    forever begin
      @(posedge bclk);
      if (lrck !== mon_lrck) begin
        mon_lrck = lrck;
        if (active) begin
          check("expected slot available", 32'(exp_q.size() != 0), 32'd1);
          e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          if (!slot_taint)
            check(lrck ? "left slot word" : "right slot word", word, {1'b0, e, 7'b0});
          slot_taint = 1'b0;
        end
        check("underflow flag", 32'(underflow), 32'(exp_uf));
        active = 1'b1;
        word = '0;
      end
      if (active) word = {word[30:0], AUD_DACDAT};
    end
  end

  function automatic bit unsafe();
    return codec_on && ((lrck == 1'b1 && c_cnt >= 30) || (lrck == 1'b0 && c_cnt <= 1));
  endfunction

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit ok;
    int n;
    n = 0;
    @(negedge clk);
    while (unsafe() && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (model_q.size() < DEPTH);
    check("write_ready before push", 32'(write_ready), 32'(ok));
    write = 1'b1;
    wl = l;
    wr = r;
    @(posedge clk);
    if (ok) model_q.push_back('{left: l, right: r});
    #1 write = 1'b0;
  endtask

  task automatic wait_slot(input logic v, input int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!(lrck == v && c_cnt == c) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("codec position reached", 32'(n < 5000), 32'd1);
  endtask

  task automatic wait_frames(input int k);
    repeat (k) begin
      wait_slot(1'b1, 31);
      wait_slot(1'b0, 1);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (model_q.size() != 0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("fifo drained in time", 32'(n < 30000), 32'd1);
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #3ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin
    int            hot, accepted, n;
    logic [DW-1:0] d;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset write_ready", 32'(write_ready), 32'd1);
    check("reset AUD_DACDAT", 32'(AUD_DACDAT), 32'd0);
    check("reset underflow", 32'(underflow), 32'd0);

    // Fill with the codec idle; the fifth pair must be dropped.
    push_pair(24'hA5F00F, 24'h5A0FF0);
    repeat (3) push_pair(DW'($urandom), DW'($urandom));
    push_pair(24'h123456, 24'h123456);

    // Codec starts mid right slot: silence until the first left slot.
    codec_on = 1'b1;
    hot = 0;
    n = 0;
    while (lrck && n < 2000) begin
      @(negedge clk);
      if (AUD_DACDAT) hot++;
      n++;
    end
    check("silent before first lrck fall", 32'(hot), 32'd0);

    // Drain, then run empty frames, then recover with extreme values.
    wait_drain();
    wait_frames(4);
    push_pair(24'h800000, 24'h7FFFFF);
    wait_frames(2);

    // Full FIFO with write held across a pop: exactly one push gets in.
    while (model_q.size() < DEPTH) push_pair(DW'($urandom), DW'($urandom));
    wait_slot(1'b1, 31);
    d = DW'($urandom);
    write = 1'b1;
    wl = d;
    wr = ~d;
    accepted = 0;
    repeat (48) begin
      if (write_ready) accepted++;
      @(negedge clk);
    end
    write = 1'b0;
    model_q.push_back('{left: d, right: ~d});
    check("pushes accepted across pop", 32'(accepted), 32'd1);
    check("write_ready after refill", 32'(write_ready), 32'd0);

    // Reset partway through a left slot of all ones.
    wait_drain();
    push_pair(24'hFFFFFF, 24'hFFFFFF);
    wait_drain();
    wait_slot(1'b0, 11);
    reset = 1'b1;
    slot_taint = 1'b1;
    model_q.delete();
    synced = 1'b0;
    exp_uf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("AUD_DACDAT after reset", 32'(AUD_DACDAT), 32'd0);
    check("underflow after reset", 32'(underflow), 32'd0);
    check("write_ready after reset", 32'(write_ready), 32'd1);
    reset = 1'b0;
    push_pair(24'h13579B, 24'h2468AC);
    wait_frames(2);

    // Random traffic.
    repeat (30) begin
      n = $urandom_range(0, 3);
      repeat (n) push_pair(DW'($urandom), DW'($urandom));
      repeat ($urandom_range(0, 700)) @(negedge clk);
    end
    wait_drain();
    wait_frames(2);

    summary();
    $finish;
  end

endmodule
